// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg: address width and type shared by PC, imem and RAS        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cpu_pkg;
  localparam int ADDR_W = 15;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage
`default_nettype wire

// File: rtl/ret_addr_stack_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ret_addr_stack_if: control-unit <-> return-address-stack bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ret_addr_stack_if
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic           push;
  addr_t          push_addr;
  logic           pop;
  logic           clr_err;
  addr_t          ret_addr;
  logic           ret_valid;
  logic [PTR_W:0] count;
  logic           empty;
  logic           full;
  logic           overflow;
  logic           underflow;

  modport master (
    output push, push_addr, pop, clr_err,
    input  ret_addr, ret_valid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, push_addr, pop, clr_err,
    output ret_addr, ret_valid, count, empty, full, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/ret_stack_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ret_stack_mem: DEPTH x ADDR_W register file, 1W/1R, reg'd read   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ret_stack_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             we,
  input  wire logic [PTR_W-1:0] waddr,
  input  wire addr_t            wdata,
  input  wire logic             re,
  input  wire logic [PTR_W-1:0] raddr,
  output      addr_t            rdata
);
  addr_t r_mem [DEPTH];
  addr_t r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read sees pre-edge contents, so a same-cycle write to raddr returns the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/ret_addr_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ret_addr_stack: circular return-address stack with sticky errors |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ret_addr_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input wire logic        clk,
  input wire logic        rst_n,
  ret_addr_stack_if.slave bus
);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ret_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic [PTR_W-1:0] w_top;
  logic [PTR_W-1:0] w_waddr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_pop_err;
  logic             w_push_ovf;
  addr_t            w_rdata;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == C_DEPTH);
  assign w_top      = r_wr_ptr - C_PTR_ONE;
  assign w_pop_ok   = bus.pop & ~w_empty;
  assign w_pop_err  = bus.pop & w_empty;
  // A tail call replaces the top in place, so it never counts as overflow.
  assign w_push_ovf = bus.push & ~w_pop_ok & w_full;
  assign w_waddr    = w_pop_ok ? w_top : r_wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_ret_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_ret_valid <= w_pop_ok;
      if (w_pop_ok && !bus.push) begin
        r_wr_ptr <= r_wr_ptr - C_PTR_ONE;
        r_count  <= r_count - C_CNT_ONE;
      end else if (bus.push && !w_pop_ok) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (!w_full) begin
          r_count <= r_count + C_CNT_ONE;
        end
      end
      // New events take priority over a same-cycle clear.
      r_overflow  <= w_push_ovf | (r_overflow  & ~bus.clr_err);
      r_underflow <= w_pop_err  | (r_underflow & ~bus.clr_err);
    end
  end

  ret_stack_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.push),
    .waddr (w_waddr),
    .wdata (bus.push_addr),
    .re    (w_pop_ok),
    .raddr (w_top),
    .rdata (w_rdata)
  );

  assign bus.ret_addr  = w_rdata;
  assign bus.ret_valid = r_ret_valid;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_ret_addr_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ret_addr_stack: directed bench with queue-based stack model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ret_addr_stack;
  import cpu_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ret_addr_stack_if #(.DEPTH(DEPTH)) bus ();

  ret_addr_stack #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: a bounded LIFO where the oldest element is dropped on overflow.
  addr_t q[$];
  addr_t m_ret   = '0;
  bit    m_valid = 1'b0;
  bit    m_ovf   = 1'b0;
  bit    m_unf   = 1'b0;
  bit    m_popok, m_ovf_ev, m_unf_ev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ret   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_popok  = bus.pop && (q.size() > 0);
      m_ovf_ev = bus.push && !m_popok && (q.size() == DEPTH);
      m_unf_ev = bus.pop && (q.size() == 0);
      m_valid  = m_popok;
      if (m_popok) m_ret = q.pop_back();
      if (bus.push) begin
        if (m_ovf_ev) void'(q.pop_front());
        q.push_back(bus.push_addr);
      end
      m_ovf = m_ovf_ev || (m_ovf && !bus.clr_err);
      m_unf = m_unf_ev || (m_unf && !bus.clr_err);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ret_valid", 32'(bus.ret_valid), 32'(m_valid));
      chk("m_ret_addr",  32'(bus.ret_addr),  32'(m_ret));
      chk("m_count",     32'(bus.count),     32'(q.size()));
      chk("m_empty",     32'(bus.empty),     32'(q.size() == 0));
      chk("m_full",      32'(bus.full),      32'(q.size() == DEPTH));
      chk("m_overflow",  32'(bus.overflow),  32'(m_ovf));
      chk("m_underflow", 32'(bus.underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input logic p, input int a, input logic o, input logic c);
    bus.push      = p;
    bus.push_addr = addr_t'(a);
    bus.pop       = o;
    bus.clr_err   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.push = 1'b0; bus.push_addr = '0; bus.pop = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_valid", 32'(bus.ret_valid), 0);
    chk("rst_addr",  32'(bus.ret_addr), 0);

    // LIFO order
    cyc(1, 'h10, 0, 0); cyc(1, 'h20, 0, 0); cyc(1, 'h30, 0, 0);
    chk("lifo_cnt3", 32'(bus.count), 3);
    cyc(0, 0, 1, 0); chk("pop1_addr", 32'(bus.ret_addr), 'h30); chk("pop1_v", 32'(bus.ret_valid), 1);
    cyc(0, 0, 1, 0); chk("pop2_addr", 32'(bus.ret_addr), 'h20); chk("pop2_v", 32'(bus.ret_valid), 1);
    cyc(0, 0, 1, 0); chk("pop3_addr", 32'(bus.ret_addr), 'h10); chk("pop3_v", 32'(bus.ret_valid), 1);
    chk("lifo_cnt0", 32'(bus.count), 0); chk("lifo_empty", 32'(bus.empty), 1);
    cyc(0, 0, 0, 0); chk("pulse_end", 32'(bus.ret_valid), 0);

    // Overflow wraps over the oldest entry
    for (int i = 1; i <= 9; i++) cyc(1, i, 0, 0);
    chk("ovf_full", 32'(bus.full), 1); chk("ovf_flag", 32'(bus.overflow), 1); chk("ovf_cnt", 32'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0);
      chk("ovf_pop", 32'(bus.ret_addr), 32'(9 - i));
    end
    chk("ovf_drained", 32'(bus.empty), 1);
    cyc(0, 0, 0, 1); chk("ovf_clr", 32'(bus.overflow), 0);

    // Underflow and clear priority
    cyc(0, 0, 1, 0);
    chk("unf_valid", 32'(bus.ret_valid), 0); chk("unf_flag", 32'(bus.underflow), 1);
    chk("unf_addr_held", 32'(bus.ret_addr), 'h2);
    cyc(0, 0, 0, 1); chk("unf_clr", 32'(bus.underflow), 0);
    cyc(0, 0, 1, 1); chk("unf_clr_vs_ev", 32'(bus.underflow), 1);
    cyc(0, 0, 0, 1);

    // Tail call
    cyc(1, 'h100, 0, 0);
    cyc(1, 'h200, 1, 0);
    chk("tail_addr", 32'(bus.ret_addr), 'h100); chk("tail_v", 32'(bus.ret_valid), 1); chk("tail_cnt", 32'(bus.count), 1);
    cyc(0, 0, 1, 0); chk("tail_pop", 32'(bus.ret_addr), 'h200);

    // Push+pop on empty
    cyc(1, 'h7FFF, 1, 0);
    chk("ep_unf", 32'(bus.underflow), 1); chk("ep_v", 32'(bus.ret_valid), 0); chk("ep_cnt", 32'(bus.count), 1);
    cyc(0, 0, 1, 0); chk("ep_pop", 32'(bus.ret_addr), 'h7FFF);
    cyc(0, 0, 0, 1);

    // Tail call while full is not an overflow
    for (int i = 0; i < 8; i++) cyc(1, 'h11 + i, 0, 0);
    cyc(1, 'h55, 1, 0);
    chk("ftail_addr", 32'(bus.ret_addr), 'h18); chk("ftail_cnt", 32'(bus.count), 8); chk("ftail_ovf", 32'(bus.overflow), 0);
    cyc(0, 0, 1, 0); chk("ftail_pop", 32'(bus.ret_addr), 'h55);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);

    // Asynchronous reset mid-pop
    for (int i = 1; i <= 4; i++) cyc(1, 'hA0 + i, 0, 0);
    cyc(0, 0, 1, 0); chk("pre_rst_pop", 32'(bus.ret_addr), 'hA4); chk("pre_rst_v", 32'(bus.ret_valid), 1);
    bus.pop = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt",   32'(bus.count), 0);
    chk("arst_valid", 32'(bus.ret_valid), 0);
    chk("arst_addr",  32'(bus.ret_addr), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    bus.pop = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(0, 0, 1, 0); chk("post_rst_unf", 32'(bus.underflow), 1);
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
